// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared constants and state encoding for the sequential binary-to-BCD converter.
package bin_to_bcd_seq_pkg;

    localparam int BIN_W_DEF   = 13;
    localparam int DIGITS_DEF  = 4;
    localparam int DIGIT_W     = 4;
    localparam logic [DIGIT_W-1:0] ADD3_THRESH = 4'd5;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_CONV = 1'b1
    } state_t;

endpackage

// File: rtl/bin_to_bcd_seq_bcd_digit_adj.sv
// Double-dabble digit cell: add 3 to a BCD digit of 5 or more before the shift.
module bcd_digit_adj
    import bin_to_bcd_seq_pkg::*;
(
    input  logic [DIGIT_W-1:0] i_Digit,
    output logic [DIGIT_W-1:0] o_Digit
);

    always_comb begin
        o_Digit = i_Digit;
        if (i_Digit >= ADD3_THRESH) begin
            o_Digit = i_Digit + 4'd3;
        end
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-add-3 converter, one binary bit per clock, start/busy/valid handshake.
// Optional leading-zero blank mask output enabled by defining BIN_TO_BCD_BLANK_EN.
//
// state   | meaning
// IDLE    | waiting for i_Start, o_BCD holds last result
// CONV    | shifting one binary bit per cycle into the BCD scratch
module bin_to_bcd_seq
    import bin_to_bcd_seq_pkg::*;
#(
    parameter int BIN_W  = BIN_W_DEF,
    parameter int DIGITS = DIGITS_DEF
) (
    input  logic                        i_CLK,
    input  logic                        i_RESET,
    input  logic [BIN_W-1:0]            i_Bin,
    input  logic                        i_Start,
    output logic                        o_Busy,
    output logic                        o_Valid,
    output logic [DIGIT_W*DIGITS-1:0]   o_BCD
`ifdef BIN_TO_BCD_BLANK_EN
   ,output logic [DIGITS-1:0]           o_Blank
`endif
);

    localparam int BCD_W = DIGIT_W * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    state_t             state_q, state_d;
    logic [BIN_W-1:0]   bin_q,   bin_d;
    logic [BCD_W-1:0]   scr_q,   scr_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [BCD_W-1:0]   bcd_q,   bcd_d;
    logic               valid_q, valid_d;
    logic               busy_q,  busy_d;

    logic [BCD_W-1:0]   scr_adj;
    logic [BCD_W-1:0]   scr_shift;

    for (genvar g = 0; g < DIGITS; g++) begin : gen_adj
        bcd_digit_adj u_adj (
            .i_Digit (scr_q[g*DIGIT_W +: DIGIT_W]),
            .o_Digit (scr_adj[g*DIGIT_W +: DIGIT_W])
        );
    end

    // The top digit's carry out is dropped: results wrap modulo 10^DIGITS.
    assign scr_shift = (scr_adj << 1) | {{(BCD_W-1){1'b0}}, bin_q[BIN_W-1]};

`ifdef BIN_TO_BCD_BLANK_EN
    logic [DIGITS-1:0]  blank_q, blank_d;
    logic [DIGITS-1:0]  blank_next;
    logic               upper_zero;

    always_comb begin
        blank_next = '0;
        upper_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            upper_zero    = upper_zero & (scr_shift[i*DIGIT_W +: DIGIT_W] == '0);
            blank_next[i] = upper_zero;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        scr_d   = scr_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        valid_d = 1'b0;
        busy_d  = busy_q;
`ifdef BIN_TO_BCD_BLANK_EN
        blank_d = blank_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (i_Start) begin
                    bin_d   = i_Bin;
                    scr_d   = '0;
                    cnt_d   = CNT_W'(BIN_W);
                    busy_d  = 1'b1;
                    state_d = ST_CONV;
                end
            end
            ST_CONV: begin
                bin_d = bin_q << 1;
                scr_d = scr_shift;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    bcd_d   = scr_shift;
                    valid_d = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
`ifdef BIN_TO_BCD_BLANK_EN
                    blank_d = blank_next;
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_CLK or posedge i_RESET) begin
        if (i_RESET) begin
            state_q <= ST_IDLE;
            bin_q   <= '0;
            scr_q   <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
`ifdef BIN_TO_BCD_BLANK_EN
            blank_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            scr_q   <= scr_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
`ifdef BIN_TO_BCD_BLANK_EN
            blank_q <= blank_d;
`endif
        end
    end

    assign o_Busy  = busy_q;
    assign o_Valid = valid_q;
    assign o_BCD   = bcd_q;
`ifdef BIN_TO_BCD_BLANK_EN
    assign o_Blank = blank_q;
`endif

endmodule
